pong_game_ctrl: RTL and testbench

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

---
 rtl/pong_game_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game controller: IDLE / SERVE / PLAY / GAME_OVER sequencing.
// Tracks scores, picks a winner and derives a per-frame tick from vsync.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   i_start       one-cycle start pulse
//   i_vsync       raw vsync, high during active rows
//   i_p1_miss     ball passed player 1 (left) edge, one-cycle pulse
//   i_p2_miss     ball passed player 2 (right) edge, one-cycle pulse
//   o_state       0=IDLE 1=SERVE 2=PLAY 3=GAME_OVER
//   o_game_active high only in PLAY
//   o_ball_hold   high outside PLAY
//   o_frame_tick  one-cycle pulse per frame (vsync falling edge)
//   o_p1_score    player 1 score
//   o_p2_score    player 2 score
//   o_winner      0=none 1=P1 2=P2
module pong_game_ctrl #(
    parameter int SCORE_LIMIT  = 9,
    parameter int SERVE_FRAMES = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    input  logic       i_vsync,
    input  logic       i_p1_miss,
    input  logic       i_p2_miss,
    output logic [1:0] o_state,
    output logic       o_game_active,
    output logic       o_ball_hold,
    output logic       o_frame_tick,
    output logic [3:0] o_p1_score,
    output logic [3:0] o_p2_score,
    output logic [1:0] o_winner
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    localparam logic [3:0] LIMIT  = 4'(SCORE_LIMIT);
    localparam logic [7:0] FRAMES = 8'(SERVE_FRAMES);

    state_t     r_state;
    state_t     w_next;
    logic       r_vsync_d;
    logic       r_tick;
    logic [7:0] r_serve_cnt;
    logic [3:0] r_p1;
    logic [3:0] r_p2;
    logic [1:0] r_winner;

    logic w_in_play;
    logic w_p1_pt;
    logic w_p2_pt;
    logic w_p1_win;
    logic w_p2_win;
    logic w_replay;
    logic w_serve_done;
    logic w_restart;

    assign w_in_play = (r_state == S_PLAY);

    // A miss by one player is a point for the other; a double miss is a replay.
    assign w_p1_pt  = w_in_play && i_p2_miss && !i_p1_miss && (r_p1 < LIMIT);
    assign w_p2_pt  = w_in_play && i_p1_miss && !i_p2_miss && (r_p2 < LIMIT);
    assign w_replay = w_in_play && i_p1_miss && i_p2_miss;
    assign w_p1_win = w_p1_pt && ((r_p1 + 4'd1) == LIMIT);
    assign w_p2_win = w_p2_pt && ((r_p2 + 4'd1) == LIMIT);

    // r_serve_cnt holds ticks already seen; this tick is the final one.
    assign w_serve_done = (r_state == S_SERVE) && r_tick &&
                          ((r_serve_cnt + 8'd1) == FRAMES);

    assign w_restart = i_start &&
                       ((r_state == S_IDLE) || (r_state == S_OVER));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_restart) w_next = S_SERVE;
            end
            S_SERVE: begin
                if (w_serve_done) w_next = S_PLAY;
            end
            S_PLAY: begin
                if (w_p1_win || w_p2_win) begin
                    w_next = S_OVER;
                end else if (w_p1_pt || w_p2_pt || w_replay) begin
                    w_next = S_SERVE;
                end
            end
            S_OVER: begin
                if (w_restart) w_next = S_SERVE;
            end
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        o_state       = r_state;
        o_game_active = (r_state == S_PLAY);
        o_ball_hold   = (r_state != S_PLAY);
        o_frame_tick  = r_tick;
        o_p1_score    = r_p1;
        o_p2_score    = r_p2;
        o_winner      = r_winner;
    end

    // Frame tick: registered falling edge of vsync
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vsync_d <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_vsync_d <= i_vsync;
            r_tick    <= r_vsync_d && !i_vsync;
        end
    end

    // Serve counter: zero outside SERVE, so every entry starts from 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_serve_cnt <= 8'd0;
        end else if (r_state != S_SERVE) begin
            r_serve_cnt <= 8'd0;
        end else if (r_tick) begin
            r_serve_cnt <= r_serve_cnt + 8'd1;
        end
    end

    // Scores and winner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p1     <= 4'd0;
            r_p2     <= 4'd0;
            r_winner <= 2'd0;
        end else if (w_restart) begin
            r_p1     <= 4'd0;
            r_p2     <= 4'd0;
            r_winner <= 2'd0;
        end else begin
            if (w_p1_pt) r_p1 <= r_p1 + 4'd1;
            if (w_p2_pt) r_p2 <= r_p2 + 4'd1;
            if (w_p1_win) begin
                r_winner <= 2'd1;
            end else if (w_p2_win) begin
                r_winner <= 2'd2;
            end
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Randomized scoreboard bench for pong_game_ctrl.
// A game-level model predicts outputs; a monitor compares every cycle.
module tb_pong_game_ctrl;

    localparam int SL = 2;
    localparam int SF = 3;

    typedef struct packed {
        logic [1:0] st;
        logic       act;
        logic       hold;
        logic       tick;
        logic [3:0] p1;
        logic [3:0] p2;
        logic [1:0] win;
    } obs_t;

    localparam obs_t RST_OBS = '{st: 2'd0, act: 1'b0, hold: 1'b1,
                                 tick: 1'b0, p1: 4'd0, p2: 4'd0,
                                 win: 2'd0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_vsync = 1'b0;
    logic       i_p1_miss = 1'b0;
    logic       i_p2_miss = 1'b0;
    logic [1:0] o_state;
    logic       o_game_active;
    logic       o_ball_hold;
    logic       o_frame_tick;
    logic [3:0] o_p1_score;
    logic [3:0] o_p2_score;
    logic [1:0] o_winner;

    pong_game_ctrl #(
        .SCORE_LIMIT (SL),
        .SERVE_FRAMES(SF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_vsync      (i_vsync),
        .i_p1_miss    (i_p1_miss),
        .i_p2_miss    (i_p2_miss),
        .o_state      (o_state),
        .o_game_active(o_game_active),
        .o_ball_hold  (o_ball_hold),
        .o_frame_tick (o_frame_tick),
        .o_p1_score   (o_p1_score),
        .o_p2_score   (o_p2_score),
        .o_winner     (o_winner)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   mon_en = 0;
    obs_t sb_q[$];

    // Game-level reference: phase 0..3, scores, winner, serve ticks seen
    int m_phase, m_p1, m_p2, m_win, m_ticks;
    bit m_vs, m_tick;
    int n_over, n_play, n_async;

    function automatic obs_t dut_obs();
        obs_t o;
        o.st   = o_state;
        o.act  = o_game_active;
        o.hold = o_ball_hold;
        o.tick = o_frame_tick;
        o.p1   = o_p1_score;
        o.p2   = o_p2_score;
        o.win  = o_winner;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.st   = 2'(m_phase);
        o.act  = (m_phase == 2);
        o.hold = (m_phase != 2);
        o.tick = m_tick;
        o.p1   = 4'(m_p1);
        o.p2   = 4'(m_p2);
        o.win  = 2'(m_win);
        return o;
    endfunction

    function automatic void model_reset();
        m_phase = 0; m_p1 = 0; m_p2 = 0; m_win = 0;
        m_ticks = 0; m_vs = 0; m_tick = 0;
    endfunction

    function automatic void new_game();
        m_p1 = 0; m_p2 = 0; m_win = 0;
        m_ticks = 0; m_phase = 1;
    endfunction

    function automatic void award(int who);
        int s;
        if (who == 1) begin m_p1++; s = m_p1; end
        else          begin m_p2++; s = m_p2; end
        if (s == SL) begin
            m_phase = 3; m_win = who;
        end else begin
            m_phase = 1; m_ticks = 0;
        end
    endfunction

    function automatic void model_edge(bit st, bit vs, bit a, bit b);
        case (m_phase)
            0: if (st) new_game();
            1: if (m_tick) begin
                   m_ticks++;
                   if (m_ticks == SF) m_phase = 2;
               end
            2: if (a && b) begin
                   m_phase = 1; m_ticks = 0;
               end else if (a) begin
                   award(2);
               end else if (b) begin
                   award(1);
               end
            default: if (st) new_game();
        endcase
        m_tick = m_vs && !vs;
        m_vs   = vs;
    endfunction

    task automatic check_now(string name, obs_t exp);
        obs_t got;
        got = dut_obs();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h required %h", name, $time,
                     got, exp);
        end
    endtask

    // One clock of stimulus; arst injects reset between edges.
    task automatic step(bit st, bit vs, bit a, bit b, bit r);
        @(negedge clk);
        i_start   = st;
        i_vsync   = vs;
        i_p1_miss = a;
        i_p2_miss = b;
        if (r && !rst) begin
            #2 rst = 1'b1;
            #1 check_now("async_rst", RST_OBS);
            n_async++;
        end else begin
            rst = r;
        end
        if (r) model_reset();
        else   model_edge(st, vs, a, b);
        if (m_phase == 2) n_play++;
        if (m_phase == 3) n_over++;
        sb_q.push_back(model_obs());
        mon_en = 1;
    endtask

    always @(posedge clk) begin
        if (mon_en) begin
            #1;
            cyc++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty cyc %0d got %h required entry",
                         cyc, dut_obs());
            end else begin
                obs_t e;
                obs_t g;
                e = sb_q.pop_front();
                g = dut_obs();
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL out cyc %0d got %h required %h",
                             cyc, g, e);
                end
            end
        end
    end

    initial begin
        bit st, vs, a, b, r;
        int rst_hold;
        bit forced;
        rst_hold = 0;
        forced   = 0;
        n_over = 0; n_play = 0; n_async = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #2 check_now("reset_state", RST_OBS);

        for (int c = 0; c < 5000; c++) begin
            vs = ($urandom_range(0, 2) == 0) ? !i_vsync : i_vsync;
            st = ($urandom_range(0, 7) == 0);
            a  = ($urandom_range(0, 5) == 0);
            b  = ($urandom_range(0, 5) == 0);
            if (rst_hold > 0) begin
                r = 1; rst_hold--;
            end else if ((!forced && m_phase == 1 && c > 300) ||
                         ($urandom_range(0, 299) == 0)) begin
                r = 1;
                forced = 1;
                rst_hold = $urandom_range(0, 2);
            end else begin
                r = 0;
            end
            step(st, vs, a, b, r);
        end
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        @(posedge clk);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d left required 0", sb_q.size());
        end
        checks++;
        if (n_play == 0 || n_over == 0 || n_async == 0) begin
            errors++;
            $display("FAIL coverage got play=%0d over=%0d arst=%0d required >0",
                     n_play, n_over, n_async);
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
